// File: rtl/ram_bus_arbiter.sv
// Registered arbiter for the data-RAM write port: grants one owner, forwards its write
// with one cycle of latency, and drops and counts writes from non-owners.
module ram_bus_arbiter #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 96,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RR_MODE  = 1,
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned MST_CH   = 0,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     MST_I,
  input  logic [NUM_CH-1:0]        iReq,
  input  logic [NUM_CH-1:0]        iWriteEnable,
  input  logic [NUM_CH*ADDR_W-1:0] iWriteAddress,
  input  logic [NUM_CH*DATA_W-1:0] iWriteData,
  output logic [NUM_CH-1:0]        oGrant,
  output logic [CH_W-1:0]          oBusOwner,
  output logic                     oWriteEnable,
  output logic [ADDR_W-1:0]        oWriteAddress,
  output logic [DATA_W-1:0]        oWriteData,
  output logic                     oCollision,
  output logic [15:0]              oCollisionCount
);

  localparam int unsigned HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam bit          HOLD_EN  = (RR_MODE != 0) && (MAX_HOLD > 0);

  typedef enum logic [1:0] {IDLE, OWNED, MASTER} stateT;

  stateT             stateQ, stateD;
  logic [CH_W-1:0]   ptrQ, ptrD;
  logic [HOLD_W-1:0] holdQ, holdD;
  logic [CH_W-1:0]   ownerD, busOwnerD, winner, searchStart;
  logic [NUM_CH-1:0] grantD, arbReq, otherReq;
  logic              doGrant;

  // First requesting channel at or after 'start', wrapping modulo NUM_CH
  function automatic logic [CH_W-1:0] pickWinner(input logic [NUM_CH-1:0] req,
                                                 input logic [CH_W-1:0]   start);
    logic [CH_W-1:0] win;
    logic            found;
    int unsigned     idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(start) + i) % NUM_CH;
      if (!found && req[CH_W'(idx)]) begin
        win   = CH_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign searchStart = (RR_MODE != 0) ? ptrQ : '0;
  assign otherReq    = iReq & ~oGrant;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ    <= IDLE;
      ptrQ      <= '0;
      holdQ     <= '0;
      oGrant    <= '0;
      oBusOwner <= '0;
    end else begin
      stateQ    <= stateD;
      ptrQ      <= ptrD;
      holdQ     <= holdD;
      oGrant    <= grantD;
      oBusOwner <= busOwnerD;
    end
  end

  // Next state: MST_I first, then release, then the hold limit
  always_comb begin
    stateD    = stateQ;
    ownerD    = oBusOwner;
    ptrD      = ptrQ;
    holdD     = holdQ;
    doGrant   = 1'b0;
    arbReq    = iReq;
    grantD    = '0;
    busOwnerD = '0;
    case (stateQ)
      IDLE: begin
        if (MST_I)      stateD  = MASTER;
        else if (|iReq) doGrant = 1'b1;
      end
      OWNED: begin
        if (MST_I) begin
          stateD = MASTER;
        end else if (!iReq[oBusOwner]) begin
          if (|otherReq) begin
            doGrant = 1'b1;
            arbReq  = otherReq;
          end else begin
            stateD = IDLE;
          end
        end else if (HOLD_EN && (holdQ == HOLD_W'(HOLD_LIM)) && (|otherReq)) begin
          doGrant = 1'b1;
          arbReq  = otherReq;
        end else if (holdQ != HOLD_W'(HOLD_LIM)) begin
          holdD = holdQ + 1'b1;
        end
      end
      MASTER: begin
        if (!MST_I) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase

    winner = pickWinner(arbReq, searchStart);
    if (doGrant) begin
      stateD = OWNED;
      ownerD = winner;
      ptrD   = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
      holdD  = '0;
    end

    case (stateD)
      OWNED: begin
        grantD[ownerD] = 1'b1;
        busOwnerD      = ownerD;
      end
      MASTER: begin
        grantD[MST_CH] = 1'b1;
        busOwnerD      = CH_W'(MST_CH);
      end
      default: ;
    endcase
  end

  logic [ADDR_W-1:0] addrArr [NUM_CH];
  logic [DATA_W-1:0] dataArr [NUM_CH];
  logic              ownerWrite, intruderWrite;

  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      addrArr[k] = iWriteAddress[k*ADDR_W +: ADDR_W];
      dataArr[k] = iWriteData[k*DATA_W +: DATA_W];
    end
  end

  // The grant seen during this cycle decides who may write at the next edge
  assign ownerWrite    = |(iWriteEnable & oGrant);
  assign intruderWrite = |(iWriteEnable & ~oGrant);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oWriteEnable    <= 1'b0;
      oWriteAddress   <= '0;
      oWriteData      <= '0;
      oCollision      <= 1'b0;
      oCollisionCount <= '0;
    end else begin
      oWriteEnable <= ownerWrite;
      if (ownerWrite) begin
        oWriteAddress <= addrArr[oBusOwner];
        oWriteData    <= dataArr[oBusOwner];
      end
      oCollision <= intruderWrite;
      if (intruderWrite && (oCollisionCount != 16'hFFFF))
        oCollisionCount <= oCollisionCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: a round-robin/hold-limit instance and a fixed-priority
// instance share the stimulus and are compared against a per-instance reference model.
module tb_ram_bus_arbiter;

  logic         Clock;
  logic         Reset;
  logic         mst;
  logic [3:0]   req, we;
  logic [63:0]  addrBus;
  logic [383:0] dataBus;

  logic [3:0]  rrGrant, fpGrant;
  logic [1:0]  rrOwner, fpOwner;
  logic        rrWe, fpWe, rrColl, fpColl;
  logic [15:0] rrAddr, fpAddr, rrCount, fpCount;
  logic [95:0] rrData, fpData;

  int aCnt = 0;
  int fCnt = 0;

  ram_bus_arbiter #(.NUM_CH(4), .DATA_W(96), .ADDR_W(16), .RR_MODE(1), .MAX_HOLD(3), .MST_CH(0)) dutRr (
    .Clock(Clock), .Reset(Reset), .MST_I(mst), .iReq(req), .iWriteEnable(we),
    .iWriteAddress(addrBus), .iWriteData(dataBus), .oGrant(rrGrant), .oBusOwner(rrOwner),
    .oWriteEnable(rrWe), .oWriteAddress(rrAddr), .oWriteData(rrData),
    .oCollision(rrColl), .oCollisionCount(rrCount));

  ram_bus_arbiter #(.NUM_CH(4), .DATA_W(96), .ADDR_W(16), .RR_MODE(0), .MAX_HOLD(0), .MST_CH(0)) dutFp (
    .Clock(Clock), .Reset(Reset), .MST_I(mst), .iReq(req), .iWriteEnable(we),
    .iWriteAddress(addrBus), .iWriteData(dataBus), .oGrant(fpGrant), .oBusOwner(fpOwner),
    .oWriteEnable(fpWe), .oWriteAddress(fpAddr), .oWriteData(fpData),
    .oCollision(fpColl), .oCollisionCount(fpCount));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Reference model, index 0 = round-robin with hold limit 3, index 1 = fixed priority
  int          mOwner  [2];   // -1 when nobody owns the bus
  bit          mMaster [2];
  int          mPtr    [2];
  int          mHeld   [2];   // cycles the current owner has displayed its grant
  bit          mWe     [2];
  logic [15:0] mAddr   [2];
  logic [95:0] mData   [2];
  bit          mColl   [2];
  int          mCnt    [2];

  function automatic int pick(int i, logic [3:0] mask);
    int c;
    for (int off = 0; off < 4; off++) begin
      c = (i == 0) ? (mPtr[i] + off) % 4 : off;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelReset(int i);
    mOwner[i] = -1; mMaster[i] = 0; mPtr[i] = 0; mHeld[i] = 0;
    mWe[i] = 0; mAddr[i] = '0; mData[i] = '0; mColl[i] = 0; mCnt[i] = 0;
  endtask

  task automatic grantTo(int i, int k);
    mOwner[i] = k;
    mHeld[i]  = 1;
    mPtr[i]   = (k + 1) % 4;
  endtask

  task automatic modelStep(int i);
    int cur;
    bit coll;
    logic [3:0] others;
    cur = mMaster[i] ? 0 : mOwner[i];
    mWe[i] = 0;
    if (cur >= 0) begin
      if (we[cur]) begin
        mWe[i]   = 1;
        mAddr[i] = addrBus[cur*16 +: 16];
        mData[i] = dataBus[cur*96 +: 96];
      end
    end
    coll = 0;
    for (int j = 0; j < 4; j++) if (we[j] && j != cur) coll = 1;
    mColl[i] = coll;
    if (coll && mCnt[i] < 65535) mCnt[i]++;

    if (mMaster[i]) begin
      if (!mst) begin mMaster[i] = 0; mOwner[i] = -1; end
    end else if (mst) begin
      mMaster[i] = 1; mOwner[i] = -1;
    end else if (mOwner[i] < 0) begin
      if (req != 0) grantTo(i, pick(i, req));
    end else begin
      others = req;
      others[mOwner[i]] = 1'b0;
      if (!req[mOwner[i]]) begin
        if (others != 0) grantTo(i, pick(i, others));
        else mOwner[i] = -1;
      end else if (i == 0 && mHeld[i] >= 3 && others != 0) begin
        grantTo(i, pick(i, others));
      end else begin
        mHeld[i]++;
      end
    end
  endtask

  function automatic logic [3:0] expGrant(int i);
    logic [3:0] g;
    g = '0;
    if (mMaster[i]) g[0] = 1'b1;
    else if (mOwner[i] >= 0) g[mOwner[i]] = 1'b1;
    return g;
  endfunction

  function automatic logic [1:0] expOwner(int i);
    if (mMaster[i]) return 2'd0;
    if (mOwner[i] >= 0) return 2'(mOwner[i]);
    return 2'd0;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    aCnt++;
    assert (obs === exp) else begin
      fCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkDut(string name, int i, logic [3:0] g, logic [1:0] o, logic w,
                        logic [15:0] a, logic [95:0] d, logic c, logic [15:0] n);
    chk($sformatf("%s.grant", name), 128'(g), 128'(expGrant(i)));
    chk($sformatf("%s.owner", name), 128'(o), 128'(expOwner(i)));
    chk($sformatf("%s.we", name), 128'(w), 128'(mWe[i]));
    chk($sformatf("%s.addr", name), 128'(a), 128'(mAddr[i]));
    chk($sformatf("%s.data", name), 128'(d), 128'(mData[i]));
    chk($sformatf("%s.coll", name), 128'(c), 128'(mColl[i]));
    chk($sformatf("%s.count", name), 128'(n), 128'(mCnt[i]));
  endtask

  task automatic checkAll();
    chkDut("rr", 0, rrGrant, rrOwner, rrWe, rrAddr, rrData, rrColl, rrCount);
    chkDut("fp", 1, fpGrant, fpOwner, fpWe, fpAddr, fpData, fpColl, fpCount);
  endtask

  task automatic cycle();
    for (int i = 0; i < 2; i++) begin
      if (Reset) modelReset(i);
      else modelStep(i);
    end
    @(posedge Clock);
    #1;
    checkAll();
  endtask

  initial begin
    Reset = 1'b1; mst = 1'b0; req = '0; we = '0; addrBus = '0; dataBus = '0;
    #1;
    modelReset(0); modelReset(1);
    checkAll();
    cycle();
    Reset = 1'b0;

    // Round-robin rotation with one-cycle release after two granted cycles
    req = 4'hF;
    cycle();
    chk("rr.first", 128'(rrGrant), 128'(4'b0001));
    for (int k = 0; k < 4; k++) begin
      cycle();
      req = 4'hF & ~(4'b0001 << k);
      cycle();
      chk("rr.rotate", 128'(rrOwner), 128'((k + 1) % 4));
      req = 4'hF;
    end

    // Fixed-priority owner write and simultaneous intruder
    req = '0; cycle();
    req = 4'b1010; cycle();
    chk("fp.owner1", 128'(fpOwner), 128'(2'd1));
    we = 4'b1010;
    addrBus[16 +: 16] = 16'h0012; addrBus[48 +: 16] = 16'h00FF;
    dataBus[96 +: 96] = 96'hA5;   dataBus[288 +: 96] = 96'hDEAD;
    cycle();
    chk("fp.wr.we", 128'(fpWe), 128'(1'b1));
    chk("fp.wr.addr", 128'(fpAddr), 128'(16'h0012));
    chk("fp.wr.data", 128'(fpData), 128'(96'hA5));
    chk("fp.wr.coll", 128'(fpColl), 128'(1'b1));
    chk("fp.wr.count", 128'(fpCount), 128'(16'd1));
    we = '0; cycle();
    chk("fp.wr.off", 128'(fpWe), 128'(1'b0));
    chk("fp.wr.hold", 128'(fpAddr), 128'(16'h0012));

    // Hold limit: ch2 keeps the bus for exactly three cycles
    req = '0; cycle();
    req = 4'b0100; cycle();
    chk("rr.hold1", 128'(rrGrant), 128'(4'b0100));
    req = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("rr.holdN", 128'(rrGrant), 128'(4'b0100));
    end
    cycle();
    chk("rr.handover", 128'(rrGrant), 128'(4'b0001));

    // Master override
    req = '0; cycle();
    req = 4'b0010; cycle();
    mst = 1'b1; we = 4'b0010;
    addrBus[16 +: 16] = 16'h1234; dataBus[96 +: 96] = 96'h77;
    cycle();
    chk("mst.grant", 128'(rrGrant), 128'(4'b0001));
    chk("mst.lastwr", 128'(rrAddr), 128'(16'h1234));
    cycle();
    chk("mst.drop", 128'(rrWe), 128'(1'b0));
    chk("mst.coll", 128'(rrColl), 128'(1'b1));
    mst = 1'b0; we = '0;
    cycle();
    chk("mst.idle", 128'(rrGrant), 128'(4'b0000));
    cycle();
    chk("mst.regrant", 128'(rrGrant), 128'(4'b0010));

    // Reset in the middle of a forwarded write
    we = 4'b0010; cycle();
    chk("rst.pre", 128'(rrWe), 128'(1'b1));
    #3 Reset = 1'b1;
    #1;
    modelReset(0); modelReset(1);
    checkAll();
    cycle();
    Reset = 1'b0; we = '0; req = '0;
    cycle(); cycle();
    chk("rst.idle", 128'(rrGrant), 128'(4'b0000));

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) mst = ~mst;
      if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       we = '0;
        1, 2:    we = 4'b0001 << $urandom_range(0, 3);
        default: we = 4'($urandom);
      endcase
      addrBus = {$urandom, $urandom};
      for (int w = 0; w < 12; w++) dataBus[w*32 +: 32] = $urandom;
      cycle();
    end

    // Collision counter saturation
    mst = 1'b0; req = '0; we = 4'hF;
    for (int n = 0; n < 70000; n++) cycle();
    chk("sat.rr", 128'(rrCount), 128'(16'hFFFF));
    chk("sat.fp", 128'(fpCount), 128'(16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", aCnt, fCnt);
    $finish;
  end

endmodule
